// File: rtl/uart_rx_ext.sv
// -----------------------------------------------------------------------------
// uart_rx_ext -- parametrised asynchronous serial receiver
//
// Receives frames of: start bit, data_bits data bits (LSB first), an optional
// odd/even parity bit and one or two stop bits. Each received word goes into a
// ready/valid holding register together with its error flags.
//
// Parameters
//   sys_clk     system clock frequency in Hz
//   rate        baud rate in bps
//   oversample  ticks per bit period (even, 8..32)
//   data_bits   data bits per frame (5..9)
//   parity      0 = none, 1 = odd, 2 = even
//   stop_bits   1 or 2
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   din         serial input (asynchronous, idles high)
//   dout        received data word
//   valid       dout and the error flags hold a frame that has not been accepted
//   ready       consumer accepts the frame when valid && ready at posedge clk
//   frame_err   a stop bit was sampled low (qualified by valid)
//   parity_err  parity mismatch (qualified by valid, always 0 without parity)
//   overrun     sticky: a frame was dropped while valid was held
//   break_det   one-cycle pulse on a break condition
//   busy        receiver FSM is not idle
//
// Build option
//   UART_RX_MAJORITY_EN : each bit is the 2-of-3 majority of the last three
//   ticks ending at mid-bit instead of a single mid-bit sample. Interface and
//   timing are the same in both builds.
// -----------------------------------------------------------------------------
module uart_rx_ext #(
   parameter int sys_clk    = 27000000,
   parameter int rate       = 19200,
   parameter int oversample = 16,
   parameter int data_bits  = 8,
   parameter int parity     = 0,
   parameter int stop_bits  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 din,
   output logic [data_bits-1:0] dout,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 break_det,
   output logic                 busy
);

   localparam int DIV = sys_clk / (rate * oversample);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(oversample);
   localparam int BW  = $clog2(data_bits);

   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] MID_START = SW'(oversample / 2 - 1);
   localparam logic [SW-1:0] BIT_LAST  = SW'(oversample - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(data_bits - 1);
   localparam logic          STOP_LAST = (stop_bits == 2) ? 1'b1 : 1'b0;
   localparam logic          PAR_EN    = (parity != 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, rx_prev_q;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [SW-1:0]        samp_q, samp_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic                 par_q, par_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 stop0_q, stop0_d;
   logic [data_bits-1:0] shreg_q, shreg_d;
   logic [data_bits-1:0] dout_q, dout_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 ovr_q, ovr_d;
   logic                 brk_q, brk_d;

   logic                 rx;
   logic                 tick;
   logic                 bit_val;
   logic                 done;
   logic                 ferr_now;
   logic                 first_zero;
   logic                 brk_now;
   logic                 perr_now;

   assign rx   = sync2_q;
   // The divider only runs while a frame is in progress so that the first
   // tick is always a fixed distance from the detected start edge.
   assign tick = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);

`ifdef UART_RX_MAJORITY_EN
   // hist_q holds rx from the two previous ticks; together with the current
   // rx they form the three samples voted on at mid-bit.
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (tick) begin
         hist_d = {hist_q[0], rx};
      end
   end

   always_ff @(posedge clk) begin
      hist_q <= hist_d;
   end

   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
   assign bit_val = rx;
`endif

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      samp_d     = samp_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      par_d      = par_q;
      ferr_acc_d = ferr_acc_q;
      stop0_d    = stop0_q;
      shreg_d    = shreg_q;
      done       = 1'b0;
      ferr_now   = ferr_acc_q | ~bit_val;
      first_zero = (stop_q == 1'b0) ? ~bit_val : stop0_q;
      brk_now    = 1'b0;
      perr_now   = 1'b0;

      if (state_q == S_IDLE || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end

      if (tick) begin
         samp_d = samp_q + 1'b1;
      end

      if (parity == 1) begin
         perr_now = ~(^shreg_q ^ par_q);
      end else if (parity == 2) begin
         perr_now = ^shreg_q ^ par_q;
      end

      case (state_q)
         S_IDLE: begin
            samp_d = '0;
            if (rx_prev_q && !rx) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick && samp_q == MID_START) begin
               samp_d = '0;
               if (bit_val) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bit_d   = '0;
                  par_d   = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (tick && samp_q == BIT_LAST) begin
               samp_d  = '0;
               shreg_d = {bit_val, shreg_q[data_bits-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == DATA_LAST) begin
                  state_d    = PAR_EN ? S_PARITY : S_STOP;
                  stop_d     = 1'b0;
                  ferr_acc_d = 1'b0;
                  stop0_d    = 1'b0;
               end
            end
         end
         S_PARITY: begin
            if (tick && samp_q == BIT_LAST) begin
               samp_d  = '0;
               par_d   = bit_val;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && samp_q == BIT_LAST) begin
               samp_d = '0;
               if (stop_q == STOP_LAST) begin
                  // Completion happens at the mid-point of the last stop bit.
                  done    = 1'b1;
                  brk_now = (shreg_q == '0) && !par_q && first_zero;
                  // A bad stop bit means the line may still be low; wait for
                  // it to go high so that no false start edge is seen.
                  state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
               end else begin
                  stop_d     = 1'b1;
                  ferr_acc_d = ferr_now;
                  stop0_d    = ~bit_val;
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rx) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Holding register: accepting clears valid and overrun; a completing frame
   // loads when the register is free or being accepted in the same cycle,
   // otherwise it is dropped and overrun is flagged.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      ovr_d   = ovr_q;
      brk_d   = 1'b0;

      if (valid_q && ready) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (done) begin
         brk_d = brk_now;
         if (!valid_q || ready) begin
            dout_d  = shreg_q;
            ferr_d  = ferr_now;
            perr_d  = perr_now;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         samp_q     <= '0;
         bit_q      <= '0;
         stop_q     <= 1'b0;
         par_q      <= 1'b0;
         ferr_acc_q <= 1'b0;
         stop0_q    <= 1'b0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         sync1_q    <= din;
         sync2_q    <= sync1_q;
         rx_prev_q  <= sync2_q;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         stop_q     <= stop_d;
         par_q      <= par_d;
         ferr_acc_q <= ferr_acc_d;
         stop0_q    <= stop0_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovr_q      <= ovr_d;
         brk_q      <= brk_d;
      end
   end

   // The shift register is fully rewritten by every frame before use.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign dout       = dout_q;
   assign valid      = valid_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;
   assign break_det  = brk_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ext -- directed bench for uart_rx_ext
//
// Two instances at 1.6 MHz / 10 kbps / x16 (160 clk per bit):
//   u_dut_a : 8N1
//   u_dut_p : 8 data bits, even parity, 1 stop bit
// -----------------------------------------------------------------------------
module tb_uart_rx_ext;

   localparam int BIT_CLK = 160;

   logic       clk = 1'b0;
   logic       reset;
   logic       din_a, din_p;
   logic       ready_a, ready_p;
   logic [7:0] dout_a, dout_p;
   logic       valid_a, valid_p;
   logic       ferr_a, ferr_p;
   logic       perr_a, perr_p;
   logic       ovr_a, ovr_p;
   logic       brk_a, brk_p;
   logic       busy_a, busy_p;

   int n_cmp = 0;
   int n_err = 0;

   int cyc = 0;
   int rises = 0;
   int rise_cyc = 0;
   int brks = 0;
   logic vld_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx_ext #(
      .sys_clk(1600000), .rate(10000), .oversample(16),
      .data_bits(8), .parity(0), .stop_bits(1)
   ) u_dut_a (
      .clk(clk), .reset(reset), .din(din_a), .dout(dout_a), .valid(valid_a),
      .ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a),
      .overrun(ovr_a), .break_det(brk_a), .busy(busy_a)
   );

   uart_rx_ext #(
      .sys_clk(1600000), .rate(10000), .oversample(16),
      .data_bits(8), .parity(2), .stop_bits(1)
   ) u_dut_p (
      .clk(clk), .reset(reset), .din(din_p), .dout(dout_p), .valid(valid_p),
      .ready(ready_p), .frame_err(ferr_p), .parity_err(perr_p),
      .overrun(ovr_p), .break_det(brk_p), .busy(busy_p)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Count valid rising edges and break pulses on the 8N1 instance.
   always @(negedge clk) begin
      if (valid_a && !vld_prev) begin
         rises    <= rises + 1;
         rise_cyc <= cyc;
      end
      if (brk_a) brks <= brks + 1;
      vld_prev <= valid_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit to_p, input logic v);
      if (to_p) din_p = v;
      else      din_a = v;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input bit to_p, input logic [7:0] data,
                             input bit use_par, input logic pbit);
      drive(to_p, 1'b0);
      for (int i = 0; i < 8; i++) drive(to_p, data[i]);
      if (use_par) drive(to_p, pbit);
      drive(to_p, 1'b1);
   endtask

   task automatic pulse_ready_a();
      ready_a = 1'b1;
      @(negedge clk);
      ready_a = 1'b0;
   endtask

   task automatic pulse_ready_p();
      ready_p = 1'b1;
      @(negedge clk);
      ready_p = 1'b0;
   endtask

   int t0, lat, r0, b0;

   initial begin
      reset = 1'b1; din_a = 1'b1; din_p = 1'b1; ready_a = 1'b0; ready_p = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_dout",  {24'd0, dout_a}, 32'h0);
      chk("rst_valid", {31'd0, valid_a}, 32'h0);
      chk("rst_ferr",  {31'd0, ferr_a}, 32'h0);
      chk("rst_ovr",   {31'd0, ovr_a}, 32'h0);
      chk("rst_busy",  {31'd0, busy_a}, 32'h0);
      chk("rst_p_flags", {26'd0, valid_p, perr_p, ferr_p, ovr_p, brk_p, busy_p}, 32'h0);

      reset = 1'b0;
      repeat (20) @(negedge clk);

      // 1. 8N1 0xA5 with latency
      t0 = cyc;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
      lat = rise_cyc - t0;
      chk("t1_valid", {31'd0, valid_a}, 32'h1);
      chk("t1_dout",  {24'd0, dout_a}, 32'hA5);
      chk("t1_flags", {30'd0, ferr_a, perr_a}, 32'h0);
      chk("t1_busy",  {31'd0, busy_a}, 32'h0);
      chk("t1_lat_in_window", {31'd0, (lat >= 1502 && lat <= 1542)}, 32'h1);
      pulse_ready_a();
      chk("t1_accept", {31'd0, valid_a}, 32'h0);

      // 2. Glitch
      r0 = rises;
      din_a = 1'b0;
      repeat (40) @(negedge clk);
      din_a = 1'b1;
      repeat (100) @(negedge clk);
      chk("t2_busy",  {31'd0, busy_a}, 32'h0);
      chk("t2_rises", rises - r0, 32'h0);
      chk("t2_valid", {31'd0, valid_a}, 32'h0);

      // 3. Even parity, 0x03 has two ones: parity bit 1 is wrong, 0 is right
      send_frame(1'b1, 8'h03, 1'b1, 1'b1);
      chk("t3_bad_valid", {31'd0, valid_p}, 32'h1);
      chk("t3_bad_dout",  {24'd0, dout_p}, 32'h03);
      chk("t3_bad_perr",  {31'd0, perr_p}, 32'h1);
      pulse_ready_p();
      send_frame(1'b1, 8'h03, 1'b1, 1'b0);
      chk("t3_good_valid", {31'd0, valid_p}, 32'h1);
      chk("t3_good_dout",  {24'd0, dout_p}, 32'h03);
      chk("t3_good_flags", {30'd0, perr_p, ferr_p}, 32'h0);
      pulse_ready_p();

      // 4. Overrun, then simultaneous accept and load
      send_frame(1'b0, 8'h11, 1'b0, 1'b0);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0);
      chk("t4_ovr_dout",  {24'd0, dout_a}, 32'h11);
      chk("t4_ovr_set",   {31'd0, ovr_a}, 32'h1);
      chk("t4_ovr_valid", {31'd0, valid_a}, 32'h1);
      pulse_ready_a();
      chk("t4_clr_valid", {31'd0, valid_a}, 32'h0);
      chk("t4_clr_ovr",   {31'd0, ovr_a}, 32'h0);
      send_frame(1'b0, 8'h11, 1'b0, 1'b0);
      fork
         send_frame(1'b0, 8'h22, 1'b0, 1'b0);
         begin
            // The new frame loads at the 1523rd edge after the start edge.
            repeat (1522) @(negedge clk);
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
            chk("t4_same_valid", {31'd0, valid_a}, 32'h1);
            chk("t4_same_dout",  {24'd0, dout_a}, 32'h22);
            chk("t4_same_ovr",   {31'd0, ovr_a}, 32'h0);
         end
      join
      pulse_ready_a();

      // 5. Break
      r0 = rises;
      b0 = brks;
      din_a = 1'b0;
      repeat (3200) @(negedge clk);
      din_a = 1'b1;
      repeat (200) @(negedge clk);
      chk("t5_rises", rises - r0, 32'h1);
      chk("t5_brks",  brks - b0, 32'h1);
      chk("t5_dout",  {24'd0, dout_a}, 32'h00);
      chk("t5_ferr",  {31'd0, ferr_a}, 32'h1);
      chk("t5_busy",  {31'd0, busy_a}, 32'h0);
      pulse_ready_a();
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
      chk("t5_next_dout",  {24'd0, dout_a}, 32'h5A);
      chk("t5_next_valid", {31'd0, valid_a}, 32'h1);
      chk("t5_next_ferr",  {31'd0, ferr_a}, 32'h0);
      chk("t5_brks_after", brks - b0, 32'h1);
      pulse_ready_a();

      // 6. Reset during bit 4 of a frame
      r0 = rises;
      drive(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 8'h3C >> i & 8'h01 ? 1'b1 : 1'b0);
      din_a = 1'b1;
      repeat (80) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_rst_busy",  {31'd0, busy_a}, 32'h0);
      chk("t6_rst_valid", {31'd0, valid_a}, 32'h0);
      reset = 1'b0;
      repeat (2000) @(negedge clk);
      chk("t6_no_output", rises - r0, 32'h0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
      chk("t6_valid", {31'd0, valid_a}, 32'h1);
      chk("t6_dout",  {24'd0, dout_a}, 32'h3C);
      chk("t6_ferr",  {31'd0, ferr_a}, 32'h0);
      chk("t6_p_quiet", {29'd0, ovr_p, brk_p, busy_p}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised serial receiver for the peripheral bus. It succeeds the fixed 8N1 receiver with configurable data width, parity, stop bits and oversampling, plus a ready/valid output holding register. Error reporting covers framing, parity, overrun and break. It sits between the external RX pin and a CPU-side register block or FIFO.

Parameters:
sys_clk, 27000000, system clock frequency in Hz
rate, 19200, baud rate in bps
oversample, 16, samples per bit; even, 8..32
data_bits, 8, data bits per frame, 5..9, LSB first
parity, 0, 0 = none, 1 = odd, 2 = even
stop_bits, 1, 1 or 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
din  in  1  serial input, asynchronous, idles high
dout  out  data_bits  received data word
valid  out  1  dout and flags hold a frame not yet accepted
ready  in  1  consumer accepts when valid && ready at posedge clk
frame_err  out  1  stop bit sampled 0; qualified by valid
parity_err  out  1  parity mismatch; qualified by valid; always 0 when parity = 0
overrun  out  1  sticky: a frame was lost while valid was held
break_det  out  1  one-cycle pulse on a break condition
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is asynchronous and active-high. On reset: dout = 0, valid = 0, frame_err = 0, parity_err = 0, overrun = 0, break_det = 0, busy = 0, FSM = IDLE, synchroniser flops = 1.
- din passes through a 2-flop synchroniser. All logic uses the synchronised value.
- Tick generator: div = sys_clk / (rate * oversample), integer division, must be at least 2. It produces a one-cycle tick every div clocks. The tick counter runs freely in all states except IDLE, where it is held cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: a falling edge on the synchronised din moves the FSM to START and clears the sample counter.
- START: at tick count oversample/2 - 1 (mid start bit), din = 1 counts as a glitch and returns the FSM to IDLE with no output. Otherwise the FSM goes to DATA with the sample counter cleared.
- DATA: each bit is sampled after oversample ticks (mid-bit) and shifted in LSB first. After data_bits samples the FSM goes to PARITY if parity != 0, else to STOP.
- PARITY: sample once at mid-bit. Odd mode expects an odd count of ones over data plus parity bit; even mode expects an even count.
- STOP: sample each stop bit at mid-bit. frame_err = 1 if any stop bit is 0. The frame completes at the mid-point of the last stop bit, not at its end.
- Completion, in the same cycle as the final stop sample:
  - If valid = 0, or valid && ready in that cycle: load dout and the flags, set valid = 1.
  - If valid && !ready: discard the new frame, keep the old dout and flags, set overrun = 1.
- Break: data all zeros, parity bit (if any) 0, and first stop bit 0. This sets frame_err, pulses break_det for one cycle, and the FSM enters WAIT_HIGH. It returns to IDLE only after din is sampled 1.
- Any frame_err (break or not) routes through WAIT_HIGH, so no false start bit is detected while din is still low.
- valid && ready at posedge clears valid and clears overrun, unless a new frame loads in that same cycle; in that case valid stays 1 with the new data.
- Latency: valid rises 1 clk after the last stop-bit mid-sample. The tick counter keeps running across bit boundaries so sampling does not drift.
- Reset mid-frame: the partial frame is discarded and nothing is emitted.

Optional Feature:
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of the samples at ticks oversample/2 - 2, - 1 and 0 relative to mid-bit. This applies to start validation, data, parity and stop bits.
- Undefined: a single sample at mid-bit is used. Interface and timing are identical either way.

Test Plan:
All scenarios use sys_clk = 1600000, rate = 10000, oversample = 16 (div = 10, 160 clk per bit), with ready held low unless stated.
1. 8N1, send 0xA5 -> valid rises about 1522 clk after the falling start edge (±20); dout = 0xA5; frame_err = 0, parity_err = 0; busy low after completion.
2. Glitch: din low for 40 clk, then high -> no valid; busy returns to 0 within 100 clk.
3. parity = 2, send 0x03 with parity bit 1 (correct bit is 0) -> valid = 1, dout = 0x03, parity_err = 1; repeat with parity bit 0 -> parity_err = 0.
4. Send 0x11 then 0x22 back-to-back -> dout = 0x11, overrun = 1. Pulse ready for 1 clk -> valid = 0, overrun = 0. Repeat with ready high during 0x22 completion -> dout = 0x22, valid stays 1, overrun = 0.
5. Break: din low for 3200 clk, then high -> exactly one valid with dout = 0x00, frame_err = 1, exactly one break_det pulse. A 0x5A frame sent afterwards is received correctly.
6. Assert reset at bit 4 of a frame, release it, then send 0x3C -> no output from the aborted frame; next valid has dout = 0x3C.
